// File: rtl/uart_wb_loader.sv
// uart_wb_loader: receives 9-byte UART command frames (sync, 4 address
// bytes, 4 data bytes, all big-endian) and turns each one into a single
// Wishbone write. Intended for preloading memories from a host without the CPU.
module uart_wb_loader #(
    parameter int         CLKS_PER_BIT = 174,
    parameter int         ACK_TIMEOUT  = 255,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rxd_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic        wr_done_o,
    output logic        err_o,
    output logic        frame_err_o
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int WAIT_W   = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA, P_BUS}   p_state_t;

    logic              rxd_meta;
    logic              rxd_sync;
    rx_state_t         rx_state;
    rx_state_t         rx_next;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_shift;
    logic              half_tick;
    logic              bit_tick;
    logic              rx_valid;
    logic              stop_err;

    p_state_t          p_state;
    p_state_t          p_next;
    logic [1:0]        byte_cnt;
    logic [31:0]       adr_shift;
    logic [31:0]       dat_shift;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ack_timeout;
    logic              last_data_byte;

    assign half_tick      = (clk_cnt == CNT_W'(HALF_BIT - 1));
    assign bit_tick       = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign ack_timeout    = (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));
    assign last_data_byte = (p_state == P_DATA) && rx_valid && (byte_cnt == 2'd3);

    // Two-flop synchronizer for the asynchronous serial line, preset to idle-high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_sync <= rxd_meta;
        end
    end

    // Receiver state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) rx_state <= R_IDLE;
        else          rx_state <= rx_next;
    end

    // Receiver next state; the stop-bit sample yields either a valid byte or a framing error.
    always_comb begin
        rx_next  = rx_state;
        rx_valid = 1'b0;
        stop_err = 1'b0;
        case (rx_state)
            R_IDLE:  if (!rxd_sync) rx_next = R_START;
            R_START: if (half_tick) rx_next = rxd_sync ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = R_STOP;
            R_STOP: begin
                if (bit_tick) begin
                    rx_next  = R_IDLE;
                    rx_valid = rxd_sync;
                    stop_err = !rxd_sync;
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    // Receiver bit timing and LSB-first shift register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == R_IDLE || rx_next != rx_state || (rx_state == R_DATA && bit_tick))
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + CNT_W'(1);
            if (rx_state == R_IDLE)
                bit_cnt <= '0;
            else if (rx_state == R_DATA && bit_tick) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= {rxd_sync, rx_shift[7:1]};
            end
        end
    end

    // Parser state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) p_state <= P_SYNC;
        else          p_state <= p_next;
    end

    // Parser next state; a broken byte abandons a partial frame but never a running bus cycle.
    always_comb begin
        p_next = p_state;
        case (p_state)
            P_SYNC: if (rx_valid && rx_shift == SYNC_BYTE) p_next = P_ADDR;
            P_ADDR: begin
                if (stop_err)                            p_next = P_SYNC;
                else if (rx_valid && byte_cnt == 2'd3)   p_next = P_DATA;
            end
            P_DATA: begin
                if (stop_err)                            p_next = P_SYNC;
                else if (last_data_byte)                 p_next = P_BUS;
            end
            P_BUS:  if (wb_ack_i || ack_timeout)         p_next = P_SYNC;
            default: p_next = P_SYNC;
        endcase
    end

    // Frame assembly, bus output registers, ack wait counter and status pulses.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            byte_cnt    <= '0;
            adr_shift   <= '0;
            dat_shift   <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wait_cnt    <= '0;
            wr_done_o   <= 1'b0;
            err_o       <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (p_state == P_SYNC)
                byte_cnt <= '0;
            else if (rx_valid && (p_state == P_ADDR || p_state == P_DATA))
                byte_cnt <= byte_cnt + 2'd1;
            if (rx_valid && p_state == P_ADDR)
                adr_shift <= {adr_shift[23:0], rx_shift};
            if (rx_valid && p_state == P_DATA)
                dat_shift <= {dat_shift[23:0], rx_shift};
            if (last_data_byte) begin
                wb_adr_o <= {adr_shift[31:2], 2'b00};
                wb_dat_o <= {dat_shift[23:0], rx_shift};
            end
            if (p_state == P_BUS)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            wr_done_o   <= (p_state == P_BUS) && wb_ack_i;
            err_o       <= (p_state == P_BUS) && !wb_ack_i && ack_timeout;
            frame_err_o <= stop_err || (rx_valid && p_state == P_BUS);
        end
    end

    assign wb_cyc_o = (p_state == P_BUS);
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = wb_cyc_o;
    assign wb_sel_o = {4{wb_cyc_o}};
    assign busy_o   = (p_state != P_SYNC);

endmodule

// File: tb/tb_uart_wb_loader.sv
// Testbench for uart_wb_loader: table of frames with expected bus writes,
// plus hand-written sequences for framing error, start glitch and reset.
module tb_uart_wb_loader;

    localparam int CPB = 8;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        rxd_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        busy_o;
    logic        wr_done_o;
    logic        err_o;
    logic        frame_err_o;

    uart_wb_loader #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TMO), .SYNC_BYTE(8'hA5)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .rxd_i      (rxd_i),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_ack_i   (wb_ack_i),
        .busy_o     (busy_o),
        .wr_done_o  (wr_done_o),
        .err_o      (err_o),
        .frame_err_o(frame_err_o)
    );

    typedef struct {
        logic [15:0] junk;
        int          n_junk;
        logic [71:0] frame;
        int          ack_delay;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        int          exp_done;
        int          exp_err;
        int          exp_len;
    } vec_t;

    vec_t vecs [5];

    int total = 0;
    int bad   = 0;

    int          n_done, n_err, n_ferr, n_bus, cur_len, last_len;
    logic [31:0] last_adr, last_dat;
    logic        bus_bad;
    logic        prev_cyc = 1'b0;
    int          ack_delay = -1;
    int          cyc_run = 0;

    always #5 clk = ~clk;

    // Bus monitor: counts pulses and bus cycles, flags illegal bus signalling.
    always @(negedge clk) begin
        n_done += int'(wr_done_o);
        n_err  += int'(err_o);
        n_ferr += int'(frame_err_o);
        if (wr_done_o && busy_o) bus_bad = 1'b1;
        if (wb_cyc_o) begin
            cur_len++;
            if (wb_sel_o !== 4'hF || wb_we_o !== 1'b1 || wb_stb_o !== 1'b1) bus_bad = 1'b1;
            if (prev_cyc && (wb_adr_o !== last_adr || wb_dat_o !== last_dat)) bus_bad = 1'b1;
            last_adr = wb_adr_o;
            last_dat = wb_dat_o;
        end else begin
            if (wb_sel_o !== 4'h0 || wb_we_o !== 1'b0 || wb_stb_o !== 1'b0) bus_bad = 1'b1;
            if (prev_cyc) begin
                n_bus++;
                last_len = cur_len;
            end
            cur_len = 0;
        end
        prev_cyc = wb_cyc_o;
    end

    // Slave model: acks in the (ack_delay+1)-th cycle of a bus cycle; negative never acks.
    always @(negedge clk) begin
        if (wb_cyc_o) begin
            wb_ack_i = (ack_delay >= 0 && cyc_run == ack_delay);
            cyc_run++;
        end else begin
            wb_ack_i = 1'b0;
            cyc_run  = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_done = 0; n_err = 0; n_ferr = 0; n_bus = 0;
        last_len = 0; bus_bad = 1'b0;
        last_adr = '0; last_dat = '0;
    endtask

    task automatic drive_bit(input logic b);
        rxd_i = b;
        wait_cycles(CPB);
    endtask

    task automatic send_bits(input logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bits(b);
        drive_bit(stop);
        drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [71:0] f);
        for (int i = 8; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_frame_end(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            wait_cycles(1);
            if (n_done + n_err > 0 && !wb_cyc_o) break;
        end
        checkOutput({name, "_end_seen"}, 32'(k < 400), 32'd1);
        wait_cycles(2 * CPB);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        clear_counts();
        ack_delay = v.ack_delay;
        for (int j = v.n_junk - 1; j >= 0; j--) send_byte(v.junk[j*8 +: 8], 1'b1);
        send_frame(v.frame);
        wait_frame_end(name);
        checkOutput({name, "_done"},  32'(n_done),  32'(v.exp_done));
        checkOutput({name, "_err"},   32'(n_err),   32'(v.exp_err));
        checkOutput({name, "_ferr"},  32'(n_ferr),  32'd0);
        checkOutput({name, "_ncyc"},  32'(n_bus),   32'd1);
        checkOutput({name, "_len"},   32'(last_len), 32'(v.exp_len));
        checkOutput({name, "_adr"},   last_adr,     v.exp_adr);
        checkOutput({name, "_dat"},   last_dat,     v.exp_dat);
        checkOutput({name, "_busbad"}, 32'(bus_bad), 32'd0);
        checkOutput({name, "_busy"},  32'(busy_o),  32'd0);
    endtask

    task automatic check_all_zero(input string name);
        checkOutput({name, "_cyc"},  32'(wb_cyc_o),  32'd0);
        checkOutput({name, "_stb"},  32'(wb_stb_o),  32'd0);
        checkOutput({name, "_we"},   32'(wb_we_o),   32'd0);
        checkOutput({name, "_sel"},  32'(wb_sel_o),  32'd0);
        checkOutput({name, "_adr"},  wb_adr_o,       32'd0);
        checkOutput({name, "_dat"},  wb_dat_o,       32'd0);
        checkOutput({name, "_busy"}, 32'(busy_o),    32'd0);
        checkOutput({name, "_pulses"}, 32'({wr_done_o, err_o, frame_err_o}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{junk: 16'h0000, n_junk: 0, frame: 72'hA5_00001004_DEADBEEF, ack_delay: 2,
                    exp_adr: 32'h00001004, exp_dat: 32'hDEADBEEF, exp_done: 1, exp_err: 0, exp_len: 3};
        vecs[1] = '{junk: 16'h00FF, n_junk: 2, frame: 72'hA5_1234567B_00000001, ack_delay: 1,
                    exp_adr: 32'h12345678, exp_dat: 32'h00000001, exp_done: 1, exp_err: 0, exp_len: 2};
        vecs[2] = '{junk: 16'h0000, n_junk: 0, frame: 72'hA5_00000020_CAFEF00D, ack_delay: -1,
                    exp_adr: 32'h00000020, exp_dat: 32'hCAFEF00D, exp_done: 0, exp_err: 1, exp_len: TMO};
        vecs[3] = '{junk: 16'h0000, n_junk: 0, frame: 72'hA5_00000024_12345678, ack_delay: 0,
                    exp_adr: 32'h00000024, exp_dat: 32'h12345678, exp_done: 1, exp_err: 0, exp_len: 1};
        vecs[4] = '{junk: 16'h0000, n_junk: 0, frame: 72'hA5_A5A5A5A6_00A5A5A5, ack_delay: 0,
                    exp_adr: 32'hA5A5A5A4, exp_dat: 32'h00A5A5A5, exp_done: 1, exp_err: 0, exp_len: 1};

        rxd_i    = 1'b1;
        wb_ack_i = 1'b0;
        wb_rst_i = 1'b1;
        clear_counts();
        wait_cycles(3);
        check_all_zero("reset");
        wb_rst_i = 1'b0;
        wait_cycles(4);
        checkOutput("post_reset_busy", 32'(busy_o), 32'd0);

        for (int v = 0; v < 2; v++) applyStimulus(vecs[v], $sformatf("vec%0d", v));

        // Framing error in the middle of an address, then a good frame.
        clear_counts();
        ack_delay = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_cycles(20 * CPB);
        checkOutput("ferr_pulse", 32'(n_ferr), 32'd1);
        checkOutput("ferr_no_cyc", 32'(n_bus), 32'd0);
        checkOutput("ferr_busy", 32'(busy_o), 32'd0);
        send_frame(72'hA5_00000040_11223344);
        wait_frame_end("ferr_good");
        checkOutput("ferr_good_done", 32'(n_done), 32'd1);
        checkOutput("ferr_good_ncyc", 32'(n_bus), 32'd1);
        checkOutput("ferr_good_adr", last_adr, 32'h00000040);
        checkOutput("ferr_good_dat", last_dat, 32'h11223344);
        checkOutput("ferr_total", 32'(n_ferr), 32'd1);

        for (int v = 2; v < 4; v++) applyStimulus(vecs[v], $sformatf("vec%0d", v));

        // Two-cycle low glitch on the line must not produce anything.
        clear_counts();
        rxd_i = 1'b0;
        wait_cycles(2);
        rxd_i = 1'b1;
        wait_cycles(4 * CPB);
        checkOutput("glitch_pulses", 32'(n_done + n_err + n_ferr), 32'd0);
        checkOutput("glitch_busy", 32'(busy_o), 32'd0);
        applyStimulus(vecs[4], "vec4_after_glitch");

        // Reset while the bus cycle is open; the next frame must decode from scratch.
        begin
            int k;
            logic [71:0] f;
            clear_counts();
            ack_delay = -1;
            f = 72'hA5_00000050_55AA55AA;
            for (int i = 8; i >= 1; i--) send_byte(f[i*8 +: 8], 1'b1);
            send_bits(f[7:0]);
            rxd_i = 1'b1;
            for (k = 0; k < 3 * CPB; k++) begin
                if (wb_cyc_o) break;
                wait_cycles(1);
            end
            checkOutput("rst_cyc_seen", 32'(wb_cyc_o), 32'd1);
            wb_rst_i = 1'b1;
            wait_cycles(1);
            check_all_zero("rst_mid");
            wb_rst_i = 1'b0;
            wait_cycles(3 * TMO);
            checkOutput("rst_no_err", 32'(n_err), 32'd0);
        end
        begin
            vec_t v;
            v = '{junk: 16'h0000, n_junk: 0, frame: 72'hA5_00000060_0BADF00D, ack_delay: 1,
                  exp_adr: 32'h00000060, exp_dat: 32'h0BADF00D, exp_done: 1, exp_err: 0, exp_len: 2};
            applyStimulus(v, "after_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
